// File: rtl/cmp_sort_pkg.sv
// cmp_sort_pkg: shared types, sizes and the comparator decision rule.
// The CMP_SORT_SIGNED_EN macro selects two's-complement ordering.
// Without it, words are ordered as unsigned values.
package cmp_sort_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_N     = 4;
    localparam int CNT_W     = $clog2(DEF_N);

`ifdef CMP_SORT_SIGNED_EN
    localparam bit SIGNED_CMP = 1'b1;
`else
    localparam bit SIGNED_CMP = 1'b0;
`endif

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A>B from the flags of S = A + ~B + 1.
    // Unsigned: a carry out (no borrow) with a nonzero difference.
    // Signed:   the sign of the true difference is positive, with a nonzero difference.
    function automatic logic cmp_gt(input logic s_msb, input logic c,
                                    input logic ovf, input logic eq);
        logic gt_u;
        logic gt_s;
        gt_u = c & ~eq;
        gt_s = ~(s_msb ^ ovf) & ~eq;
        return SIGNED_CMP ? gt_s : gt_u;
    endfunction

endpackage

// File: rtl/cmp_sort_if.sv
// cmp_sort_if: load stream, drain stream and status for cmp_sort_ctrl.
// The master side is the data source and consumer. The slave side is the sorter.
interface cmp_sort_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/cmp_sort_sub_cmp.sv
// sub_cmp: combinational ripple subtractor A-B (M=1: B inverted, carry-in 1).
// It produces the difference, carry, overflow, equal, greater and less flags.
// The package rule gives the ordering, which is unsigned or signed depending on CMP_SORT_SIGNED_EN.
module sub_cmp
    import cmp_sort_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_s,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_eq,
    output logic             o_gt,
    output logic             o_lt
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_bx;

    assign w_bx   = ~i_b;
    assign w_c[0] = 1'b1;

    // One full adder per bit; the carry ripples from LSB to MSB.
    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign o_s[g]   = i_a[g] ^ w_bx[g] ^ w_c[g];
        assign w_c[g+1] = (i_a[g] & w_bx[g]) | (w_c[g] & (i_a[g] ^ w_bx[g]));
    end

    assign o_carry = w_c[WIDTH];
    assign o_ovf   = w_c[WIDTH] ^ w_c[WIDTH-1];
    assign o_eq    = (o_s == '0);
    assign o_gt    = cmp_gt(o_s[WIDTH-1], o_carry, o_ovf, o_eq);
    assign o_lt    = SIGNED_CMP ? (o_s[WIDTH-1] ^ o_ovf) : ~o_carry;

endmodule

// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: loads N words, bubble-sorts them in place, then streams them out in ascending order.
// One shared comparator performs one compare/swap per SORT cycle.
// CMP_SORT_SIGNED_EN selects two's-complement ordering; the default ordering is unsigned.
module cmp_sort_ctrl
    import cmp_sort_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic          clk,
    input  logic          rst,
    cmp_sort_if.slave     bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST     = CW'(N - 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 2);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_mem [N];
    logic [CW-1:0]    r_load_cnt;
    logic [CW-1:0]    r_idx;
    logic [CW-1:0]    r_pass;
    logic [CW-1:0]    r_out_cnt;
    logic             r_swapped;

    logic [CW-1:0]    w_idx1;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_gt;
    logic             w_swapped_now;
    logic             w_pass_end;
    logic             w_in_fire;
    logic             w_out_fire;

    logic [WIDTH-1:0] w_cmp_s;
    logic             w_cmp_c;
    logic             w_cmp_ovf;
    logic             w_cmp_eq;
    logic             w_cmp_lt;
    logic             w_unused;

    assign w_idx1 = r_idx + CW'(1);
    assign w_a    = r_mem[r_idx];
    assign w_b    = r_mem[w_idx1];

    sub_cmp #(.WIDTH(WIDTH)) u_cmp (
        .i_a     (w_a),
        .i_b     (w_b),
        .o_s     (w_cmp_s),
        .o_carry (w_cmp_c),
        .o_ovf   (w_cmp_ovf),
        .o_eq    (w_cmp_eq),
        .o_gt    (w_gt),
        .o_lt    (w_cmp_lt)
    );

    // Only the greater-than decision steers the swap; the remaining flags are diagnostic.
    assign w_unused = ^{w_cmp_s, w_cmp_c, w_cmp_ovf, w_cmp_eq, w_cmp_lt};

    assign bus.in_ready  = (r_state == LOAD);
    assign bus.out_valid = (r_state == DRAIN);
    assign bus.busy      = (r_state == SORT) || (r_state == DRAIN);
    assign bus.out_data  = r_mem[r_out_cnt];
    assign bus.out_last  = (r_state == DRAIN) && (r_out_cnt == LAST);

    assign w_in_fire     = bus.in_valid && (r_state == LOAD);
    assign w_out_fire    = bus.out_ready && (r_state == DRAIN);
    // The pass verdict must include a swap that happens on the pass's final compare.
    assign w_swapped_now = r_swapped | w_gt;
    assign w_pass_end    = (r_state == SORT) && (r_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= LOAD;
        else     r_state <= w_next;
    end

    // Next-state logic. The sort stops early after a pass with no swaps, or after N-1 passes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD:    if (w_in_fire && (r_load_cnt == LAST)) w_next = SORT;
            SORT:    if (w_pass_end && (!w_swapped_now || (r_pass == LAST_IDX))) w_next = DRAIN;
            DRAIN:   if (w_out_fire && (r_out_cnt == LAST)) w_next = LOAD;
            default: w_next = LOAD;
        endcase
    end

    // Load, compare and drain counters, and the per-pass swap flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_cnt <= '0;
            r_idx      <= '0;
            r_pass     <= '0;
            r_out_cnt  <= '0;
            r_swapped  <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        if (r_load_cnt == LAST) begin
                            r_load_cnt <= '0;
                            r_idx      <= '0;
                            r_pass     <= '0;
                            r_swapped  <= 1'b0;
                        end else begin
                            r_load_cnt <= r_load_cnt + CW'(1);
                        end
                    end
                end
                SORT: begin
                    if (w_pass_end) begin
                        r_idx     <= '0;
                        r_swapped <= 1'b0;
                        if (w_swapped_now && (r_pass != LAST_IDX))
                            r_pass <= r_pass + CW'(1);
                        else
                            r_out_cnt <= '0;
                    end else begin
                        r_idx     <= w_idx1;
                        r_swapped <= w_swapped_now;
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        if (r_out_cnt == LAST) r_out_cnt <= '0;
                        else                   r_out_cnt <= r_out_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Word storage. Words are written during LOAD, and both entries are exchanged in one edge on a SORT swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        end else if (w_in_fire) begin
            r_mem[r_load_cnt] <= bus.in_data;
        end else if ((r_state == SORT) && w_gt) begin
            r_mem[r_idx]  <= w_b;
            r_mem[w_idx1] <= w_a;
        end
    end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb_cmp_sort_ctrl: directed bench for cmp_sort_ctrl (N=4, WIDTH=4).
// Words are packed as {w3,w2,w1,w0}; w0 is loaded or expected first.
// Expected orderings follow CMP_SORT_SIGNED_EN when that macro is defined for the build.
module tb_cmp_sort_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cmp_sort_if #(.WIDTH(4)) bus ();

    cmp_sort_ctrl #(.WIDTH(4), .N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef CMP_SORT_SIGNED_EN
    // -4,-5,5,-7 -> -7,-5,-4,5 ; -6,6,-6,1 -> -6,-6,1,6
    localparam logic [15:0] EXP_MIX = {4'd5, 4'd12, 4'd11, 4'd9};
    localparam logic [15:0] EXP_DUP = {4'd6, 4'd1, 4'd10, 4'd10};
`else
    localparam logic [15:0] EXP_MIX = {4'd12, 4'd11, 4'd9, 4'd5};
    localparam logic [15:0] EXP_DUP = {4'd10, 4'd10, 4'd6, 4'd1};
`endif
    localparam logic [15:0] IN_MIX  = {4'd9, 4'd5, 4'd11, 4'd12};
    localparam logic [15:0] IN_DUP  = {4'd1, 4'd10, 4'd6, 4'd10};
    localparam logic [15:0] SEQ_123 = {4'd4, 4'd3, 4'd2, 4'd1};
    localparam logic [15:0] REV_123 = {4'd1, 4'd2, 4'd3, 4'd4};
    localparam logic [15:0] IN_3021 = {4'd1, 4'd2, 4'd0, 4'd3};
    localparam logic [15:0] EXP_0123 = {4'd3, 4'd2, 4'd1, 4'd0};
    localparam logic [15:0] ALL7    = {4'd7, 4'd7, 4'd7, 4'd7};

    task automatic load_burst(input logic [15:0] words);
        for (int k = 0; k < 4; k++) begin
            int t;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = words[4*k +: 4];
            t = 0;
            while (!bus.in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready word %0d got %b exp 1", k, bus.in_ready);
            end
            @(posedge clk);
        end
        #1 bus.in_valid = 1'b0;
    endtask

    // Counts SORT cycles: busy high, out_valid low, sampled at negedges.
    task automatic wait_sort(output int cyc);
        cyc = 0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_load got %b exp 1", bus.busy);
        end
        while (bus.out_valid !== 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sort_timeout got out_valid %b exp 1", bus.out_valid);
        end
    endtask

    // Entered at a negedge with DRAIN active. stall_k >= 0 stalls out_ready for 5 cycles at that word.
    task automatic drain(input logic [15:0] exp, input int stall_k, input string tag);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s valid_busy word %0d got %b%b exp 11", tag, k, bus.out_valid, bus.busy);
            end
            checks++;
            if (bus.out_data !== exp[4*k +: 4]) begin
                errors++;
                $display("FAIL %s data word %0d got %0d exp %0d", tag, k, bus.out_data, exp[4*k +: 4]);
            end
            checks++;
            if (bus.out_last !== (k == 3)) begin
                errors++;
                $display("FAIL %s last word %0d got %b exp %b", tag, k, bus.out_last, (k == 3));
            end
            if (k == stall_k) begin
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (bus.out_data !== exp[4*k +: 4] || bus.out_last !== (k == 3) || bus.out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL %s stall word %0d got %0d/%b exp %0d/%b", tag, k,
                                 bus.out_data, bus.out_last, exp[4*k +: 4], (k == 3));
                    end
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after_drain got rdy %b busy %b ov %b exp 1 0 0", tag,
                     bus.in_ready, bus.busy, bus.out_valid);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.busy !== 1'b0 || bus.out_data !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got rdy %b ov %b ol %b busy %b od %0d exp 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_mix();
        int cyc;
        load_burst(IN_MIX);
        wait_sort(cyc);
        drain(EXP_MIX, -1, "mix");
    endtask

    task automatic test_latency();
        int cyc;
        load_burst(SEQ_123);
        wait_sort(cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL sorted_latency got %0d exp 3", cyc);
        end
        drain(SEQ_123, -1, "sorted");
        load_burst(REV_123);
        wait_sort(cyc);
        checks++;
        if (cyc != 9) begin
            errors++;
            $display("FAIL reversed_latency got %0d exp 9", cyc);
        end
        drain(SEQ_123, -1, "reversed");
    endtask

    task automatic test_duplicates();
        int cyc;
        load_burst(IN_DUP);
        wait_sort(cyc);
        drain(EXP_DUP, -1, "dup");
        // All-equal words never swap, so one pass is enough.
        load_burst(ALL7);
        wait_sort(cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL equal_latency got %0d exp 3", cyc);
        end
        drain(ALL7, -1, "equal");
    endtask

    task automatic test_backpressure();
        int cyc;
        load_burst(IN_MIX);
        wait_sort(cyc);
        drain(EXP_MIX, 1, "stall1");
        load_burst(IN_3021);
        wait_sort(cyc);
        drain(EXP_0123, 3, "stall_last");
    endtask

    task automatic test_ignore_in_valid();
        int cyc;
        load_burst(IN_3021);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hF;
        wait_sort(cyc);
        drain(EXP_0123, -1, "ignore");
    endtask

    task automatic test_reset_mid_sort();
        int cyc;
        load_burst(IN_MIX);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_sort got rdy %b busy %b ov %b exp 1 0 0",
                     bus.in_ready, bus.busy, bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        load_burst(IN_3021);
        wait_sort(cyc);
        drain(EXP_0123, -1, "after_rst");
    endtask

    task automatic test_back_to_back();
        int cyc;
        load_burst(REV_123);
        wait_sort(cyc);
        drain(SEQ_123, -1, "b2b_a");
        load_burst(IN_DUP);
        wait_sort(cyc);
        drain(EXP_DUP, -1, "b2b_b");
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_mix();
        test_latency();
        test_duplicates();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid_sort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
